mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-to-one memory request arbiter that sits directly downstream of `cpu`. It merges the CPU's instruction port (`imem_*`) and data port (`mem_*`) onto a single 16-bit memory port (`pmem_*`) that feeds the L2 cache. It serves one transaction at a time, latching the winning request into registers. On a contended idle cycle it grants alternately between the two sides, so neither starves. Each side sees the standard LC-3b handshake: it holds read or write high until it sees resp.

## Interface
No parameters.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `imem_address`, `imem_wdata` input 16: instruction-side request.
- `imem_read`, `imem_write` input 1: instruction-side request strobes.
- `imem_byte_enable` input 2: instruction-side byte enables.
- `imem_rdata` output 16: instruction-side read data.
- `imem_resp` output 1: instruction-side completion pulse.
- `mem_address`, `mem_wdata` input 16: data-side request.
- `mem_read`, `mem_write` input 1: data-side request strobes.
- `mem_byte_enable` input 2: data-side byte enables.
- `mem_rdata` output 16: data-side read data.
- `mem_resp` output 1: data-side completion pulse.
- `pmem_address`, `pmem_wdata` output 16: downstream request, registered.
- `pmem_read`, `pmem_write` output 1: downstream strobes, registered.
- `pmem_byte_enable` output 2: downstream byte enables, registered.
- `pmem_rdata` input 16: downstream read data.
- `pmem_resp` input 1: downstream completion, valid for one cycle.

## Operation
- The state machine has five states: IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
- A side is *requesting* when its read or write input is high.
- If a side asserts both read and write, it is treated as a write and read is ignored.
- **IDLE:**
  - If exactly one side is requesting, grant it.
  - If both are requesting, grant the side not recorded in `last_grant`.
  - On grant, capture that side's address, wdata, read/write, and byte enable into the `pmem_*` registers, set `last_grant`, and go to BUSY_x.
  - For a read, `pmem_byte_enable` is forced to 2'b11 and `pmem_wdata` holds the captured value.
- **BUSY_x:**
  - Hold all `pmem_*` outputs stable.
  - When `pmem_resp` is sampled high: clear `pmem_read`/`pmem_write`, load `pmem_rdata` into side x's rdata register (reads only; writes leave it unchanged), and go to DONE_x.
- **DONE_x:**
  - `x_resp` is high for exactly this cycle.
  - Next state is always IDLE. No new grant is made in DONE, because the requester is still holding its strobe this cycle.
- Side rdata registers hold their value until the next read completion on that side.
- Once a request is granted it always completes, even if the requester drops its strobe before `pmem_resp`. The resp pulse is still issued.
- `pmem_resp` sampled in IDLE or DONE is a stray and is ignored. It causes no state change and no data capture.
- Reset (asynchronous, `reset_n` low):
  - state = IDLE and `last_grant` = I, so the data side wins the first tie.
  - All `pmem_*` outputs = 0, `imem_resp` = `mem_resp` = 0, `imem_rdata` = `mem_rdata` = 16'h0000.
  - Reset mid-transaction abandons the transaction; no resp is issued for it.

## Timing
- Request sampled high at edge N makes `pmem_*` valid in cycle N..N+1.
- With `pmem_resp` high in cycle k, `x_resp` and `x_rdata` are valid in cycle k+1.
- With zero-wait memory (resp in the first BUSY cycle), request to resp is 2 cycles.
- One transaction takes 3 cycles (IDLE, BUSY, DONE) plus memory wait cycles.
- A requester may present its next request in the cycle after resp. It is arbitrated in IDLE on the following edge.
- `x_resp` is never high for more than one consecutive cycle.
- `imem_resp` and `mem_resp` are never high in the same cycle.

## Test plan
- **Data read:** after reset, `mem_read`=1 at 16'h1234; memory returns 16'hBEEF with `pmem_resp` 3 cycles after `pmem_read` rises.
  - `pmem_address`=16'h1234 and `pmem_byte_enable`=2'b11.
  - `mem_resp` pulses one cycle with `mem_rdata`=16'hBEEF.
  - `imem_resp` stays 0.
- **Tie alternation:** both sides issue reads continuously with zero-wait memory.
  - Grant order is D, I, D, I.
  - Each `x_resp` is exactly 3 cycles apart on the shared port.
- **Data write:** `mem_write`=1, address 16'h0040, wdata 16'h00AA, byte enable 2'b01.
  - `pmem_write`=1, `pmem_read`=0, `pmem_byte_enable`=2'b01, `pmem_wdata`=16'h00AA.
  - `mem_resp` pulses; `mem_rdata` keeps its prior value.
- **Instruction read byte enables:** `imem_read` with `imem_byte_enable`=2'b00.
  - `pmem_byte_enable`=2'b11.
- **Reset mid-transaction:** drop `reset_n` during BUSY_I.
  - All outputs go to 0 immediately.
  - A `pmem_resp` arriving after release produces no `imem_resp`.
- **Abandoned / illegal requests:**
  - Requester drops `mem_read` in BUSY_D: the transaction completes and `mem_resp` still pulses.
  - Both `mem_read` and `mem_write` asserted: serviced as a write.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-to-one instruction/data arbiter onto a single registered memory port
module mem_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] imem_address,
  input  logic [15:0] imem_wdata,
  input  logic        imem_read,
  input  logic        imem_write,
  input  logic [1:0]  imem_byte_enable,
  output logic [15:0] imem_rdata,
  output logic        imem_resp,
  input  logic [15:0] mem_address,
  input  logic [15:0] mem_wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_byte_enable,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic [15:0] pmem_address,
  output logic [15:0] pmem_wdata,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [1:0]  pmem_byte_enable,
  input  logic [15:0] pmem_rdata,
  input  logic        pmem_resp
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] i_rdata_q, i_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  logic        i_req, d_req, pick_d;
  logic [15:0] sel_addr, sel_wdata;
  logic        sel_write;
  logic [1:0]  sel_be;

  assign i_req = imem_read | imem_write;
  assign d_req = mem_read | mem_write;
  // Data side wins when alone, or on a tie when instruction side had the last grant.
  assign pick_d = d_req & (~i_req | (last_grant_q == GRANT_I));

  assign sel_addr  = pick_d ? mem_address : imem_address;
  assign sel_wdata = pick_d ? mem_wdata : imem_wdata;
  assign sel_write = pick_d ? mem_write : imem_write;
  assign sel_be    = pick_d ? mem_byte_enable : imem_byte_enable;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    read_d       = read_q;
    write_d      = write_q;
    be_d         = be_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          last_grant_d = pick_d ? GRANT_D : GRANT_I;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          write_d      = sel_write;
          read_d       = ~sel_write;
          be_d         = sel_write ? sel_be : 2'b11;
          state_d      = pick_d ? BUSY_D : BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (pmem_resp) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q && state_q == BUSY_I) i_rdata_d = pmem_rdata;
          if (read_q && state_q == BUSY_D) d_rdata_d = pmem_rdata;
          state_d = (state_q == BUSY_I) ? DONE_I : DONE_D;
        end
      end
      DONE_I, DONE_D: state_d = IDLE;
      default:        state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      addr_q       <= 16'h0000;
      wdata_q      <= 16'h0000;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      be_q         <= 2'b00;
      i_rdata_q    <= 16'h0000;
      d_rdata_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      read_q       <= read_d;
      write_q      <= write_d;
      be_q         <= be_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign pmem_address     = addr_q;
  assign pmem_wdata       = wdata_q;
  assign pmem_read        = read_q;
  assign pmem_write       = write_q;
  assign pmem_byte_enable = be_q;
  assign imem_rdata       = i_rdata_q;
  assign mem_rdata        = d_rdata_q;
  assign imem_resp        = (state_q == DONE_I);
  assign mem_resp         = (state_q == DONE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] imem_address = '0, imem_wdata = '0;
  logic        imem_read = 1'b0, imem_write = 1'b0;
  logic [1:0]  imem_byte_enable = '0;
  logic [15:0] imem_rdata;
  logic        imem_resp;
  logic [15:0] mem_address = '0, mem_wdata = '0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [1:0]  mem_byte_enable = '0;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic [15:0] pmem_address, pmem_wdata;
  logic        pmem_read, pmem_write;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata = '0;
  logic        pmem_resp = 1'b0;

  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .imem_address(imem_address), .imem_wdata(imem_wdata), .imem_read(imem_read),
    .imem_write(imem_write), .imem_byte_enable(imem_byte_enable),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_read(pmem_read),
    .pmem_write(pmem_write), .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        side;
    logic [15:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   resp_cyc[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  logic prev_i = 1'b0, prev_d = 1'b0;

  bit          mem_en = 1'b1;
  bit          mem_fixed = 1'b0;
  int          mem_lat = 0;
  int          mem_cnt = 0;
  logic [15:0] mem_data = 16'h0000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers after mem_lat BUSY cycles with either a fixed word or ~address.
  initial forever begin
    @(negedge clk);
    if (mem_en) begin
      pmem_resp = 1'b0;
      if (pmem_read || pmem_write) begin
        if (mem_cnt == mem_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem_fixed ? mem_data : ~pmem_address;
          mem_cnt    = 0;
        end else mem_cnt++;
      end else mem_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard on every response pulse.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset_n) begin
      prev_i = 1'b0;
      prev_d = 1'b0;
    end else begin
      if (imem_resp && mem_resp) chk("resp_overlap", 32'(mem_resp), 32'(~imem_resp));
      if ((imem_resp && prev_i) || (mem_resp && prev_d)) chk("resp_consecutive", 32'(imem_resp & prev_i | mem_resp & prev_d), 32'd0);
      if (imem_resp || mem_resp) begin
        resp_cyc.push_back(cyc);
        if (exp_q.size() == 0) chk("unexpected_resp", 32'(exp_q.size()), 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("resp_side", 32'(mem_resp), 32'(e.side));
          chk("resp_rdata", 32'(mem_resp ? mem_rdata : imem_rdata), 32'(e.rdata));
        end
      end
      prev_i = imem_resp;
      prev_d = mem_resp;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    imem_read = 1'b0; imem_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_resp(input logic side, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (side ? mem_resp : imem_resp) got = 1'b1;
    end
    chk(nm, 32'(got), 32'd1);
    if (side) begin mem_read = 1'b0; mem_write = 1'b0; end
    else begin imem_read = 1'b0; imem_write = 1'b0; end
  endtask

  initial begin
    #1;
    chk("rst_pmem_addr", 32'(pmem_address), 32'h0);
    chk("rst_pmem_strobes", 32'({pmem_read, pmem_write, pmem_byte_enable}), 32'h0);
    chk("rst_resp", 32'({imem_resp, mem_resp}), 32'h0);
    chk("rst_rdata", 32'({imem_rdata, mem_rdata}), 32'h0);
    do_reset();

    // Data read, fixed data, 3-cycle wait
    mem_lat = 3; mem_fixed = 1'b1; mem_data = 16'hBEEF;
    exp_q.push_back('{1'b1, 16'hBEEF});
    mem_address = 16'h1234; mem_read = 1'b1;
    @(posedge clk); #1;
    chk("rd_addr", 32'(pmem_address), 32'h1234);
    chk("rd_be", 32'(pmem_byte_enable), 32'h3);
    chk("rd_strobes", 32'({pmem_read, pmem_write}), 32'h2);
    wait_resp(1'b1, "rd_resp_wait");
    mem_fixed = 1'b0;

    // Tie alternation with zero-wait memory
    do_reset();
    mem_lat = 0;
    resp_cyc.delete();
    exp_q.push_back('{1'b1, 16'hFDFF});
    exp_q.push_back('{1'b0, 16'hFEFF});
    exp_q.push_back('{1'b1, 16'hFDFF});
    exp_q.push_back('{1'b0, 16'hFEFF});
    imem_address = 16'h0100; imem_read = 1'b1;
    mem_address = 16'h0200; mem_read = 1'b1;
    for (int i = 0; i < 60 && resp_cyc.size() < 4; i++) @(negedge clk);
    imem_read = 1'b0; mem_read = 1'b0;
    chk("tie_count", 32'(resp_cyc.size()), 32'd4);
    if (resp_cyc.size() >= 4)
      for (int i = 1; i < 4; i++) chk("tie_spacing", 32'(resp_cyc[i] - resp_cyc[i-1]), 32'd3);

    // Data write keeps prior rdata
    @(negedge clk);
    exp_q.push_back('{1'b1, 16'hFDFF});
    mem_address = 16'h0040; mem_wdata = 16'h00AA; mem_byte_enable = 2'b01; mem_write = 1'b1;
    @(posedge clk); #1;
    chk("wr_strobes", 32'({pmem_read, pmem_write}), 32'h1);
    chk("wr_be", 32'(pmem_byte_enable), 32'h1);
    chk("wr_wdata", 32'(pmem_wdata), 32'h00AA);
    chk("wr_addr", 32'(pmem_address), 32'h0040);
    wait_resp(1'b1, "wr_resp_wait");

    // Instruction read forces byte enables
    @(negedge clk);
    exp_q.push_back('{1'b0, 16'hFCFF});
    imem_address = 16'h0300; imem_byte_enable = 2'b00; imem_read = 1'b1;
    @(posedge clk); #1;
    chk("ird_be", 32'(pmem_byte_enable), 32'h3);
    wait_resp(1'b0, "ird_resp_wait");

    // Read and write together is a write
    @(negedge clk);
    exp_q.push_back('{1'b1, 16'hFDFF});
    mem_address = 16'h0050; mem_wdata = 16'h1357; mem_byte_enable = 2'b10;
    mem_read = 1'b1; mem_write = 1'b1;
    @(posedge clk); #1;
    chk("rw_strobes", 32'({pmem_read, pmem_write}), 32'h1);
    chk("rw_be", 32'(pmem_byte_enable), 32'h2);
    wait_resp(1'b1, "rw_resp_wait");

    // Requester drops its strobe mid-transaction
    @(negedge clk);
    mem_lat = 2;
    exp_q.push_back('{1'b1, 16'hFF9F});
    mem_address = 16'h0060; mem_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_read = 1'b0;
    wait_resp(1'b1, "abandon_resp_wait");

    // Reset during BUSY_I, then a stray response
    @(negedge clk);
    mem_en = 1'b0; pmem_resp = 1'b0;
    imem_address = 16'h0070; imem_read = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy_read", 32'(pmem_read), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_pmem", 32'({pmem_address, pmem_read, pmem_write, pmem_byte_enable}), 32'h0);
    chk("mid_rst_rdata", 32'({imem_rdata, mem_rdata}), 32'h0);
    @(negedge clk);
    imem_read = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pmem_rdata = 16'hDEAD; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    repeat (4) @(negedge clk);
    chk("stray_rdata", 32'(imem_rdata), 32'h0);
    chk("stray_strobes", 32'({pmem_read, pmem_write}), 32'h0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
